// File: rtl/alu4_pkg.sv
// Shared definitions for the alu4 issue wrapper.
// Holds the default operand and opcode widths, the issue FSM state encoding and a helper that
// gives the packed command width ({a, b, op}) stored in the command FIFO.
package alu4_pkg;

  localparam int unsigned DefDataW = 4;
  localparam int unsigned DefOpW   = 4;
  localparam int unsigned DefCmdW  = DefDataW * 2 + DefOpW;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrive = 2'd1,
    StHold  = 2'd2
  } state_e;

  function automatic int unsigned cmd_width(int unsigned data_w, int unsigned op_w);
    return data_w * 2 + op_w;
  endfunction

endpackage

// File: rtl/alu4_cmd_fifo.sv
// Generic synchronous FIFO for the alu4 command stream.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   push_i, wdata_i   write request and data (ignored while full)
//   pop_i, rdata_o    read request (ignored while empty) and head-of-queue data
//   full_o, empty_o   status, both derived from the registered count
//   count_o           number of stored entries
module alu4_cmd_fifo #(
  parameter int unsigned Width = 12,
  parameter int unsigned Depth = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [Width-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Depth is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/alu4_issue.sv
// Sequential front/back-end wrapper around the combinational alu4.
// Commands {a, b, op} are queued in a FIFO, presented one at a time on registered operand
// outputs, and the ALU's x/y are captured into a result register offered over valid/ready.
// Ports:
//   clk_i, rst_i                     clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o          command handshake; cmd_a_i, cmd_b_i, cmd_op_i payload
//   alu_a_o, alu_b_o, alu_op_o       registered operands to alu4
//   alu_x_i, alu_y_i                 alu4 outputs
//   res_valid_o/res_ready_i          result handshake; res_x_o, res_y_o payload
//   res_tag_o                        8-bit result sequence tag (only with ALU4_ISSUE_TAG_EN)
//   busy_o                           FSM active or commands queued
// Optional feature macro: ALU4_ISSUE_TAG_EN.
module alu4_issue
  import alu4_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned OP_W   = DefOpW,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [DATA_W-1:0] cmd_a_i,
  input  logic [DATA_W-1:0] cmd_b_i,
  input  logic [OP_W-1:0]   cmd_op_i,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  output logic [OP_W-1:0]   alu_op_o,
  input  logic [DATA_W-1:0] alu_x_i,
  input  logic [DATA_W-1:0] alu_y_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [DATA_W-1:0] res_x_o,
  output logic [DATA_W-1:0] res_y_o,
`ifdef ALU4_ISSUE_TAG_EN
  output logic [7:0]        res_tag_o,
`endif
  output logic              busy_o
);

  localparam int unsigned CmdW = cmd_width(DATA_W, OP_W);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [OP_W-1:0]     alu_op_q, alu_op_d;
  logic [DATA_W-1:0]   res_x_q, res_x_d, res_y_q, res_y_d;
  logic                res_valid_q, res_valid_d;

  logic                fifo_full, fifo_empty, fifo_pop;
  logic [CmdW-1:0]     fifo_rdata;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [DATA_W-1:0]   head_a, head_b;
  logic [OP_W-1:0]     head_op;

  alu4_cmd_fifo #(
    .Width (CmdW),
    .Depth (DEPTH)
  ) u_cmd_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (cmd_valid_i),
    .wdata_i ({cmd_a_i, cmd_b_i, cmd_op_i}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign {head_a, head_b, head_op} = fifo_rdata;

  // Ready comes from the registered count, so a full FIFO refuses even while it pops.
  assign cmd_ready_o = !fifo_full;

  // Pop only from IDLE, or from HOLD in the same edge the result is consumed.
  assign fifo_pop = !fifo_empty &&
                    ((state_q == StIdle) || ((state_q == StHold) && res_ready_i));

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    res_x_d     = res_x_q;
    res_y_d     = res_y_q;
    res_valid_d = res_valid_q;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          {alu_a_d, alu_b_d, alu_op_d} = {head_a, head_b, head_op};
          state_d = StDrive;
        end
      end
      StDrive: begin
        res_x_d     = alu_x_i;
        res_y_d     = alu_y_i;
        res_valid_d = 1'b1;
        state_d     = StHold;
      end
      StHold: begin
        if (res_ready_i) begin
          res_valid_d = 1'b0;
          if (!fifo_empty) begin
            {alu_a_d, alu_b_d, alu_op_d} = {head_a, head_b, head_op};
            state_d = StDrive;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      res_x_q     <= '0;
      res_y_q     <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      res_x_q     <= res_x_d;
      res_y_q     <= res_y_d;
      res_valid_q <= res_valid_d;
    end
  end

`ifdef ALU4_ISSUE_TAG_EN
  logic [7:0] tag_cnt_q, tag_cnt_d, res_tag_q, res_tag_d;

  // The counter advances on each consumed result; DRIVE snapshots it with the data.
  always_comb begin
    tag_cnt_d = tag_cnt_q;
    res_tag_d = res_tag_q;
    if (res_valid_q && res_ready_i) tag_cnt_d = tag_cnt_q + 8'd1;
    if (state_q == StDrive)         res_tag_d = tag_cnt_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag_cnt_q <= '0;
      res_tag_q <= '0;
    end else begin
      tag_cnt_q <= tag_cnt_d;
      res_tag_q <= res_tag_d;
    end
  end

  assign res_tag_o = res_tag_q;
`endif

  assign alu_a_o     = alu_a_q;
  assign alu_b_o     = alu_b_q;
  assign alu_op_o    = alu_op_q;
  assign res_x_o     = res_x_q;
  assign res_y_o     = res_y_q;
  assign res_valid_o = res_valid_q;
  assign busy_o      = (state_q != StIdle) || (fifo_count != '0);

endmodule

// File: tb/tb_alu4_issue.sv
// Self-checking bench for alu4_issue with a behavioural stand-in for alu4.
// Accepted commands are queued at the handshake; a monitor pops and compares each result.
module tb_alu4_issue;

  localparam int unsigned DW    = 4;
  localparam int unsigned OW    = 4;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [DW-1:0] cmd_a = '0, cmd_b = '0;
  logic [OW-1:0] cmd_op = '0;
  logic [DW-1:0] alu_a, alu_b, alu_x, alu_y;
  logic [OW-1:0] alu_op;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [DW-1:0] res_x, res_y;
  logic          busy;
`ifdef ALU4_ISSUE_TAG_EN
  logic [7:0]    res_tag;
`endif

  alu4_issue #(
    .DATA_W (DW),
    .OP_W   (OW),
    .DEPTH  (DEPTH)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_a_i     (cmd_a),
    .cmd_b_i     (cmd_b),
    .cmd_op_i    (cmd_op),
    .alu_a_o     (alu_a),
    .alu_b_o     (alu_b),
    .alu_op_o    (alu_op),
    .alu_x_i     (alu_x),
    .alu_y_i     (alu_y),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_x_o     (res_x),
    .res_y_o     (res_y),
`ifdef ALU4_ISSUE_TAG_EN
    .res_tag_o   (res_tag),
`endif
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  // Stand-in alu4: returns {x, y}.
  function automatic logic [7:0] alu_model(logic [3:0] a, logic [3:0] b, logic [3:0] op);
    logic [4:0] s;
    case (op)
      4'd0:    begin s = a + b; return {s[3:0], 3'b000, s[4]}; end
      4'd1:    return {a - b, 3'b000, (a < b)};
      4'd2:    return {a & b, a | b};
      4'd3:    return {a ^ b, ~(a ^ b)};
      4'd14:   return {~a, ~b};
      default: return {a, b ^ op};
    endcase
  endfunction

  always_comb {alu_x, alu_y} = alu_model(alu_a, alu_b, alu_op);

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] op;
  } cmd_t;

  cmd_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   res_cnt = 0;
  bit   stream_on = 1'b0;
  int   stream_n  = 0;
  int   last_cyc  = 0;
  bit   rand_rdy  = 1'b0;
  bit   hold_vld  = 1'b0;
  logic [3:0] hold_x, hold_y;
  int   exp_tag   = 0;
  int   last_tag  = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event did not occur within bound (t=%0t)", name, $time);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      res_ready = 1'($urandom_range(0, 1));
    end
  end

  // Inputs change at posedge+1, so the negedge sees what the next edge will act on.
  always @(negedge clk) begin
    logic [7:0] ref_xy;
    if (rst) begin
      exp_q.delete();
      exp_tag  = 0;
      hold_vld = 1'b0;
    end else begin
      if (cmd_valid && cmd_ready) exp_q.push_back('{a: cmd_a, b: cmd_b, op: cmd_op});
      if (res_valid) begin
        if (hold_vld) begin
          check("hold_x_stable", 32'(res_x), 32'(hold_x));
          check("hold_y_stable", 32'(res_y), 32'(hold_y));
        end
        if (res_ready) begin
          hold_vld = 1'b0;
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_result: got x=%0h y=%0h expected none", res_x, res_y);
          end else begin
            cmd_t c;
            c = exp_q.pop_front();
            ref_xy = alu_model(c.a, c.b, c.op);
            check("res_x", 32'(res_x), 32'(ref_xy[7:4]));
            check("res_y", 32'(res_y), 32'(ref_xy[3:0]));
`ifdef ALU4_ISSUE_TAG_EN
            check("res_tag", 32'(res_tag), 32'(exp_tag));
            last_tag = int'(res_tag);
`endif
            exp_tag = (exp_tag + 1) % 256;
            res_cnt++;
            if (stream_on) begin
              if (stream_n > 0) check("stream_gap", 32'(cyc - last_cyc), 32'd2);
              last_cyc = cyc;
              stream_n++;
            end
          end
        end else begin
          hold_vld = 1'b1;
          hold_x   = res_x;
          hold_y   = res_y;
        end
      end else begin
        hold_vld = 1'b0;
      end
    end
  end

  task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    bit done = 1'b0;
    int n = 0;
    cmd_a = a;
    cmd_b = b;
    cmd_op = op;
    cmd_valid = 1'b1;
    while (!done && n < 200) begin
      @(negedge clk);
      done = cmd_ready;
      @(posedge clk);
      #1;
      n++;
    end
    cmd_valid = 1'b0;
    if (!done) fail_now("push_timeout");
  endtask

  task automatic push_rand();
    push(4'($urandom), 4'($urandom), 4'($urandom));
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || res_valid) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 1000) fail_now("drain_timeout");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ref_xy;
    int base;

    do_reset();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_alu_ops", {20'd0, alu_a, alu_b, alu_op}, 32'd0);
    check("rst_res_xy", {24'd0, res_x, res_y}, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Single op: latency and no bypass.
    res_ready = 1'b1;
    cmd_a = 4'd2; cmd_b = 4'd3; cmd_op = 4'd3; cmd_valid = 1'b1;
    @(posedge clk); #1; cmd_valid = 1'b0;
    check("no_bypass_op", 32'(alu_op), 32'd0);
    @(posedge clk); #1;
    check("single_alu_ops", {20'd0, alu_a, alu_b, alu_op}, {20'd0, 4'd2, 4'd3, 4'd3});
    check("single_early_valid", 32'(res_valid), 32'd0);
    @(posedge clk); #1;
    ref_xy = alu_model(4'd2, 4'd3, 4'd3);
    check("single_valid", 32'(res_valid), 32'd1);
    check("single_xy", {24'd0, res_x, res_y}, {24'd0, ref_xy});
    @(posedge clk); #1;
    check("single_busy_after", 32'(busy), 32'd0);
    check("single_valid_after", 32'(res_valid), 32'd0);

    // Streaming back-to-back with res_ready high.
    stream_on = 1'b1;
    push(4'd0, 4'd0, 4'd0);
    push(4'd1, 4'd1, 4'd1);
    push(4'd2, 4'd3, 4'd3);
    push(4'd15, 4'd15, 4'd14);
    drain();
    stream_on = 1'b0;
    check("stream_count", 32'(stream_n), 32'd4);

    // Backpressure: one in flight plus DEPTH queued fills the FIFO.
    res_ready = 1'b0;
    repeat (DEPTH + 1) push_rand();
    check("full_cmd_ready", 32'(cmd_ready), 32'd0);
    check("full_busy", 32'(busy), 32'd1);
    repeat (4) begin @(posedge clk); #1; end
    res_ready = 1'b1;
    push_rand();
    drain();

    // Reset while holding a result with commands queued.
    res_ready = 1'b0;
    repeat (4) push_rand();
    repeat (3) begin @(posedge clk); #1; end
    check("pre_rst_valid", 32'(res_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_valid", 32'(res_valid), 32'd0);
    check("midrst_alu_ops", {20'd0, alu_a, alu_b, alu_op}, 32'd0);
    check("midrst_res_xy", {24'd0, res_x, res_y}, 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    res_ready = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    check("midrst_no_stale", 32'(res_valid), 32'd0);

    // Pointer wrap with random backpressure.
    base = res_cnt;
    rand_rdy = 1'b1;
    repeat (2 * DEPTH + 1 + 8) push_rand();
    rand_rdy = 1'b0;
    @(posedge clk); #1;
    res_ready = 1'b1;
    drain();
    check("wrap_count", 32'(res_cnt - base), 32'(2 * DEPTH + 1 + 8));

`ifdef ALU4_ISSUE_TAG_EN
    do_reset();
    res_ready = 1'b1;
    repeat (258) push_rand();
    drain();
    check("tag_last", 32'(last_tag), 32'd1);
`endif

    repeat (3) begin @(posedge clk); #1; end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
